// File: rtl/cmos_pattern_gen.sv
// Synthetic parallel-video source: generates fv/lv framed 10-bit pixel streams with
// parameterised timing and four selectable test patterns. All outputs are registered.
module cmos_pattern_gen #(
    parameter int unsigned DATA_WDT = 10,
    parameter int unsigned H_ACTIVE = 1920,
    parameter int unsigned H_BLANK  = 64,
    parameter int unsigned V_ACTIVE = 1280,
    parameter int unsigned V_FRONT  = 16,
    parameter int unsigned V_BACK   = 16,
    parameter int unsigned V_BLANK  = 256
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic                single_shot_i,
    input  logic [1:0]          pattern_sel_i,
    output logic [DATA_WDT-1:0] pd_o,
    output logic                fv_o,
    output logic                lv_o,
    output logic                frame_done_o,
    output logic [15:0]         frame_cnt_o,
    output logic                busy_o
);

    localparam int unsigned XWidth     = $clog2(H_ACTIVE);
    localparam int unsigned YWidth     = $clog2(V_ACTIVE + 1);
    localparam int unsigned BlankMaxA  = (V_FRONT > H_BLANK) ? V_FRONT : H_BLANK;
    localparam int unsigned BlankMaxB  = (V_BACK > V_BLANK) ? V_BACK : V_BLANK;
    localparam int unsigned BlankMax   = (BlankMaxA > BlankMaxB) ? BlankMaxA : BlankMaxB;
    localparam int unsigned BlankWidth = $clog2(BlankMax + 1);
    localparam logic [9:0]  LfsrSeed   = 10'h3FF;

    typedef enum logic [2:0] {
        StIdle,
        StFvLead,
        StLine,
        StHblank,
        StFvTrail,
        StVblank
    } state_e;

    state_e                state_q, state_d;
    logic [BlankWidth-1:0] blank_q, blank_d;
    logic [XWidth-1:0]     x_q, x_d;
    logic [YWidth-1:0]     y_q, y_d;
    logic [9:0]            lfsr_q, lfsr_d;
    logic [1:0]            pat_q, pat_d;
    logic                  single_q, single_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic [DATA_WDT-1:0]   pd_q, pd_d;
    logic                  fv_q, fv_d;
    logic                  lv_q, lv_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic [9:0]            pix;
    logic                  frame_end;

    // Sequencer: state transitions and frame/line/blanking counters.
    always_comb begin
        state_d  = state_q;
        blank_d  = blank_q;
        x_d      = x_q;
        y_d      = y_q;
        lfsr_d   = lfsr_q;
        pat_d    = pat_q;
        single_d = single_q;
        case (state_q)
            StIdle: begin
                if (enable_i || single_shot_i) begin
                    state_d  = StFvLead;
                    blank_d  = '0;
                    x_d      = '0;
                    y_d      = '0;
                    lfsr_d   = LfsrSeed;
                    pat_d    = pattern_sel_i;
                    // Continuous mode wins when both requests arrive together.
                    single_d = ~enable_i;
                end
            end
            StFvLead: begin
                if (blank_q == BlankWidth'(V_FRONT - 1)) begin
                    state_d = StLine;
                    blank_d = '0;
                end else begin
                    blank_d = blank_q + 1'b1;
                end
            end
            StLine: begin
                lfsr_d = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
                if (x_q == XWidth'(H_ACTIVE - 1)) begin
                    x_d     = '0;
                    blank_d = '0;
                    state_d = (y_q < YWidth'(V_ACTIVE - 1)) ? StHblank : StFvTrail;
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
            StHblank: begin
                if (blank_q == BlankWidth'(H_BLANK - 1)) begin
                    state_d = StLine;
                    blank_d = '0;
                    y_d     = y_q + 1'b1;
                end else begin
                    blank_d = blank_q + 1'b1;
                end
            end
            StFvTrail: begin
                if (blank_q == BlankWidth'(V_BACK - 1)) begin
                    state_d = StVblank;
                    blank_d = '0;
                end else begin
                    blank_d = blank_q + 1'b1;
                end
            end
            StVblank: begin
                if (blank_q == BlankWidth'(V_BLANK - 1)) begin
                    blank_d = '0;
                    if (enable_i && !single_q) begin
                        state_d = StFvLead;
                        x_d     = '0;
                        y_d     = '0;
                        lfsr_d  = LfsrSeed;
                        pat_d   = pattern_sel_i;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    blank_d = blank_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Pixel pattern selection from the current counters.
    always_comb begin
        pix = lfsr_q;
        case (pat_q)
            2'd0:    pix = 10'(x_q);
            2'd1:    pix = 10'(x_q) + 10'(y_q);
            2'd2:    pix = frame_cnt_q[9:0];
            default: pix = lfsr_q;
        endcase
    end

    // Output next-state: bus levels follow the state one cycle later.
    always_comb begin
        frame_end   = (state_q == StVblank) && (blank_q == '0);
        fv_d        = (state_q == StFvLead) || (state_q == StLine) ||
                      (state_q == StHblank) || (state_q == StFvTrail);
        lv_d        = (state_q == StLine);
        pd_d        = lv_d ? DATA_WDT'(pix) : '0;
        done_d      = frame_end;
        busy_d      = (state_q != StIdle);
        frame_cnt_d = frame_end ? frame_cnt_q + 16'd1 : frame_cnt_q;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            blank_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
            lfsr_q      <= LfsrSeed;
            pat_q       <= '0;
            single_q    <= 1'b0;
            frame_cnt_q <= '0;
            pd_q        <= '0;
            fv_q        <= 1'b0;
            lv_q        <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            blank_q     <= blank_d;
            x_q         <= x_d;
            y_q         <= y_d;
            lfsr_q      <= lfsr_d;
            pat_q       <= pat_d;
            single_q    <= single_d;
            frame_cnt_q <= frame_cnt_d;
            pd_q        <= pd_d;
            fv_q        <= fv_d;
            lv_q        <= lv_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign pd_o         = pd_q;
    assign fv_o         = fv_q;
    assign lv_o         = lv_q;
    assign frame_done_o = done_q;
    assign frame_cnt_o  = frame_cnt_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_cmos_pattern_gen.sv
// Scoreboard bench for cmos_pattern_gen using small frame timing (8x3, fv 31, period 35).
module tb_cmos_pattern_gen;

    localparam int HA  = 8;
    localparam int HB  = 2;
    localparam int VA  = 3;
    localparam int VF  = 2;
    localparam int VBK = 1;
    localparam int VBL = 4;

    logic        clk           = 1'b0;
    logic        rst_i         = 1'b1;
    logic        enable_i      = 1'b0;
    logic        single_shot_i = 1'b0;
    logic [1:0]  pattern_sel_i = 2'd0;
    logic [9:0]  pd_o;
    logic        fv_o;
    logic        lv_o;
    logic        frame_done_o;
    logic [15:0] frame_cnt_o;
    logic        busy_o;

    cmos_pattern_gen #(
        .DATA_WDT(10),
        .H_ACTIVE(HA),
        .H_BLANK (HB),
        .V_ACTIVE(VA),
        .V_FRONT (VF),
        .V_BACK  (VBK),
        .V_BLANK (VBL)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .enable_i     (enable_i),
        .single_shot_i(single_shot_i),
        .pattern_sel_i(pattern_sel_i),
        .pd_o         (pd_o),
        .fv_o         (fv_o),
        .lv_o         (lv_o),
        .frame_done_o (frame_done_o),
        .frame_cnt_o  (frame_cnt_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [9:0] exp_q[$];
    int fv_lens[$], periods[$], lv_lens[$], gaps[$];
    int frame_pix[$], frame_lines[$], busy_gap[$], fcnts[$];
    int done_cnt, pd_bad, pix_in_frame, lines_in_frame;
    int fv_rise_cyc, fv_fall_cyc, lv_rise_cyc, lv_fall_cyc;
    bit have_rise;
    logic fv_prev = 1'b0, lv_prev = 1'b0, busy_prev = 1'b0, done_prev = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] ref_v);
        checks++;
        if (obs !== ref_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, ref_v);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_stats();
        fv_lens.delete();
        periods.delete();
        lv_lens.delete();
        gaps.delete();
        frame_pix.delete();
        frame_lines.delete();
        busy_gap.delete();
        fcnts.delete();
        done_cnt       = 0;
        pix_in_frame   = 0;
        lines_in_frame = 0;
        have_rise      = 1'b0;
    endtask

    // Expected pixels of one frame; pattern 3 uses the x^10+x^7+1 reference LFSR.
    task automatic push_frame(input int pat, input logic [15:0] fcnt);
        logic [9:0] l;
        logic [9:0] v;
        l = 10'h3FF;
        for (int y = 0; y < VA; y++) begin
            for (int x = 0; x < HA; x++) begin
                case (pat)
                    0:       v = 10'(x);
                    1:       v = 10'(x + y);
                    2:       v = fcnt[9:0];
                    default: begin
                        v = l;
                        l = {l[8:0], l[9] ^ l[6]};
                    end
                endcase
                exp_q.push_back(v);
            end
        end
    endtask

    task automatic wait_done(input int n);
        int k;
        k = 0;
        while (done_cnt < n && k < 500) begin
            step();
            k++;
        end
        check_val("wait_done", 32'(done_cnt >= n), 1);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy_o && k < 200) begin
            step();
            k++;
        end
        check_val("wait_idle", 32'(busy_o), 0);
    endtask

    task automatic pulse_single(input logic [1:0] pat);
        pattern_sel_i = pat;
        single_shot_i = 1'b1;
        step();
        single_shot_i = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check_val({tag, "_pd"}, 32'(pd_o), 0);
        check_val({tag, "_fv"}, 32'(fv_o), 0);
        check_val({tag, "_lv"}, 32'(lv_o), 0);
        check_val({tag, "_done"}, 32'(frame_done_o), 0);
        check_val({tag, "_cnt"}, 32'(frame_cnt_o), 0);
        check_val({tag, "_busy"}, 32'(busy_o), 0);
    endtask

    // Output monitor: pixel scoreboard plus fv/lv/busy timing statistics.
    always @(negedge clk) begin
        cyc++;
        if (lv_o) begin
            check_val("pix_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check_val("pix", 32'(pd_o), 32'(exp_q.pop_front()));
            pix_in_frame++;
            if (!lv_prev) begin
                lines_in_frame++;
                lv_rise_cyc = cyc;
                if (lines_in_frame > 1) gaps.push_back(cyc - lv_fall_cyc);
            end
        end else begin
            if (pd_o != 10'd0) pd_bad++;
            if (lv_prev) begin
                lv_lens.push_back(cyc - lv_rise_cyc);
                lv_fall_cyc = cyc;
            end
        end
        if (fv_o && !fv_prev) begin
            if (have_rise) periods.push_back(cyc - fv_rise_cyc);
            have_rise      = 1'b1;
            fv_rise_cyc    = cyc;
            pix_in_frame   = 0;
            lines_in_frame = 0;
        end
        if (!fv_o && fv_prev) begin
            fv_lens.push_back(cyc - fv_rise_cyc);
            frame_pix.push_back(pix_in_frame);
            frame_lines.push_back(lines_in_frame);
            fv_fall_cyc = cyc;
        end
        if (!busy_o && busy_prev) busy_gap.push_back(cyc - fv_fall_cyc);
        if (frame_done_o) begin
            done_cnt++;
            fcnts.push_back(int'(frame_cnt_o));
            check_val("done_at_fv_fall", 32'({fv_prev, fv_o}), 32'(2'b10));
            check_val("done_one_cycle", 32'(done_prev), 0);
        end
        fv_prev   = fv_o;
        lv_prev   = lv_o;
        busy_prev = busy_o;
        done_prev = frame_done_o;
    end

    initial begin
        int k;
        int fv_at, lv_at, busy_at;

        // Reset state
        rst_i = 1'b1;
        step();
        step();
        check_zero_outputs("reset");
        rst_i = 1'b0;
        clear_stats();

        // Continuous pattern 0, three frames
        for (int f = 0; f < 3; f++) push_frame(0, 16'd0);
        pattern_sel_i = 2'd0;
        enable_i      = 1'b1;
        wait_done(3);
        enable_i = 1'b0;
        wait_idle();
        check_val("s1_fv_frames", 32'(fv_lens.size()), 3);
        foreach (fv_lens[i]) check_val("s1_fv_len", 32'(fv_lens[i]), 31);
        check_val("s1_periods", 32'(periods.size()), 2);
        foreach (periods[i]) check_val("s1_period", 32'(periods[i]), 35);
        check_val("s1_lv_bursts", 32'(lv_lens.size()), 9);
        foreach (lv_lens[i]) check_val("s1_lv_len", 32'(lv_lens[i]), 8);
        check_val("s1_gaps", 32'(gaps.size()), 6);
        foreach (gaps[i]) check_val("s1_lv_gap", 32'(gaps[i]), 2);
        foreach (frame_lines[i]) check_val("s1_lines", 32'(frame_lines[i]), 3);
        check_val("s1_fcnts", 32'(fcnts.size()), 3);
        foreach (fcnts[i]) check_val("s1_frame_cnt", 32'(fcnts[i]), 32'(i + 1));
        check_val("s1_done_cnt", 32'(done_cnt), 3);
        check_val("s1_sb_empty", 32'(exp_q.size()), 0);

        // Continuous pattern 3, two identical LFSR frames
        clear_stats();
        push_frame(3, 16'd0);
        push_frame(3, 16'd0);
        pattern_sel_i = 2'd3;
        enable_i      = 1'b1;
        wait_done(2);
        enable_i = 1'b0;
        wait_idle();
        check_val("s2_frames", 32'(frame_pix.size()), 2);
        foreach (frame_pix[i]) check_val("s2_pix_count", 32'(frame_pix[i]), 24);
        check_val("s2_sb_empty", 32'(exp_q.size()), 0);

        // Single shot with a second pulse mid-frame
        clear_stats();
        push_frame(0, 16'd0);
        pattern_sel_i = 2'd0;
        single_shot_i = 1'b1;
        step();
        single_shot_i = 1'b0;
        k       = 1;
        fv_at   = 0;
        lv_at   = 0;
        busy_at = 0;
        while (k < 70) begin
            step();
            k++;
            if (fv_o && fv_at == 0) fv_at = k;
            if (lv_o && lv_at == 0) lv_at = k;
            if (!busy_o && busy_at == 0 && fv_at != 0) busy_at = k;
            single_shot_i = (k == 15);
        end
        single_shot_i = 1'b0;
        check_val("s3_fv_start", 32'(fv_at), 2);
        check_val("s3_lv_start", 32'(lv_at), 4);
        check_val("s3_busy_fall", 32'(busy_at), 37);
        check_val("s3_done_cnt", 32'(done_cnt), 1);
        check_val("s3_fv_frames", 32'(fv_lens.size()), 1);
        check_val("s3_busy_end", 32'(busy_o), 0);
        check_val("s3_sb_empty", 32'(exp_q.size()), 0);

        // Pattern 1, pattern_sel change ignored, enable dropped during line 1
        clear_stats();
        push_frame(1, 16'd0);
        pattern_sel_i = 2'd1;
        enable_i      = 1'b1;
        k = 0;
        while (!(lines_in_frame == 1 && lv_o) && k < 100) begin
            step();
            k++;
        end
        pattern_sel_i = 2'd0;
        k = 0;
        while (!(lines_in_frame == 2 && lv_o) && k < 100) begin
            step();
            k++;
        end
        check_val("s4_in_line1", 32'(lines_in_frame), 2);
        enable_i = 1'b0;
        wait_done(1);
        wait_idle();
        check_val("s4_done_cnt", 32'(done_cnt), 1);
        check_val("s4_pix", 32'(frame_pix.size() > 0 ? frame_pix[0] : -1), 24);
        check_val("s4_vblank", 32'(busy_gap.size() > 0 ? busy_gap[0] : -1), 4);
        check_val("s4_sb_empty", 32'(exp_q.size()), 0);

        // Reset during HBLANK, then restart from a fresh LFSR seed
        clear_stats();
        push_frame(3, 16'd0);
        pattern_sel_i = 2'd3;
        enable_i      = 1'b1;
        k = 0;
        while (lv_lens.size() < 1 && k < 100) begin
            step();
            k++;
        end
        check_val("s5_in_hblank", 32'(lv_lens.size()), 1);
        rst_i    = 1'b1;
        enable_i = 1'b0;
        step();
        check_zero_outputs("s5_reset");
        rst_i = 1'b0;
        exp_q.delete();
        clear_stats();
        push_frame(3, 16'd0);
        pulse_single(2'd3);
        wait_done(1);
        wait_idle();
        check_val("s5_frame_cnt", 32'(frame_cnt_o), 1);
        check_val("s5_sb_empty", 32'(exp_q.size()), 0);

        // Frame counter wrap and flat pattern 2
        clear_stats();
        force dut.frame_cnt_q = 16'hFFFF;
        step();
        release dut.frame_cnt_q;
        check_val("s6_preload", 32'(frame_cnt_o), 32'h0000FFFF);
        push_frame(2, 16'hFFFF);
        pulse_single(2'd2);
        wait_done(1);
        check_val("s6_wrap", 32'(frame_cnt_o), 0);
        wait_idle();
        push_frame(2, 16'h0000);
        pulse_single(2'd2);
        wait_done(2);
        wait_idle();
        check_val("s6_after_wrap", 32'(frame_cnt_o), 1);
        check_val("s6_sb_empty", 32'(exp_q.size()), 0);

        check_val("pd_zero_when_lv_low", 32'(pd_bad), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmos_pattern_gen.md
# cmos_pattern_gen

Synthetic parallel-video source that drives the same 10-bit pixel / frame-valid / line-valid bus the MIPI-to-CMOS bridge produces. It stands in for the camera path during histogram, Slave-FIFO and board bring-up work. It generates frames with parameterised timing and four selectable pixel patterns. Outputs are registered, so they can feed the histogram input registers directly through the same mux as `cmos_data`/`cmos_fv`/`cmos_lv`.

## Interface
Parameters:
- `DATA_WDT`, 10, pixel width (patterns defined for 10; wider pads MSBs with 0)
- `H_ACTIVE`, 1920, pixels per line (lv high cycles), ≥2
- `H_BLANK`, 64, lv-low cycles between lines inside a frame, ≥1
- `V_ACTIVE`, 1280, lines per frame, ≥1
- `V_FRONT`, 16, fv-high/lv-low cycles before first line, ≥1
- `V_BACK`, 16, fv-high/lv-low cycles after last line, ≥1
- `V_BLANK`, 256, fv-low cycles between frames, ≥1

Ports:
- `clk_i` in 1: pixel clock; sole clock.
- `rst_i` in 1: synchronous, active-high reset.
- `enable_i` in 1: continuous streaming request, level.
- `single_shot_i` in 1: one-cycle pulse; in IDLE, starts exactly one frame.
- `pattern_sel_i` in 2: pattern select, latched at frame start.
- `pd_o` out DATA_WDT: pixel data.
- `fv_o` out 1: frame valid.
- `lv_o` out 1: line valid.
- `frame_done_o` out 1: one-cycle pulse per completed frame.
- `frame_cnt_o` out 16: completed-frame count.
- `busy_o` out 1: high whenever state ≠ IDLE.

## Operation
- States: IDLE, FV_LEAD, LINE, HBLANK, FV_TRAIL, VBLANK.
- IDLE → FV_LEAD when `enable_i` or `single_shot_i` is sampled high. `pattern_sel_i` is latched into `pat_q`. The frame is marked single-shot only if `enable_i` is low; continuous mode wins when both are high.
- FV_LEAD (V_FRONT cycles) → LINE.
- LINE (H_ACTIVE cycles):
  - → HBLANK if the line index < V_ACTIVE−1.
  - Otherwise → FV_TRAIL.
- HBLANK (H_BLANK cycles) → LINE, with the line index incremented.
- FV_TRAIL (V_BACK cycles) → VBLANK.
- VBLANK (V_BLANK cycles):
  - Last cycle → FV_LEAD, with `pattern_sel_i` relatched, if `enable_i` is high and the frame was not single-shot.
  - Otherwise → IDLE.
- Counters: column x (0..H_ACTIVE−1) and line y (0..V_ACTIVE−1) are zeroed at FV_LEAD entry. A single blanking counter is reused by each non-LINE state.
- Output levels by state:
  - `fv_o` is high in FV_LEAD, LINE, HBLANK and FV_TRAIL; low otherwise.
  - `lv_o` is high only in LINE.
  - `pd_o` is 0 whenever `lv_o` is low.
- Patterns, with all arithmetic modulo 2^10:
  - 0: `pd = x[9:0]` (horizontal ramp).
  - 1: `pd = x + y` (diagonal).
  - 2: `pd = frame_cnt_o[9:0]` (flat per frame).
  - 3: 10-bit Fibonacci LFSR, taps x^10+x^7+1. Seeded to 10'h3FF at FV_LEAD entry. The current value is output, then the LFSR advances once per active pixel.
- `frame_cnt_o` increments on the first VBLANK cycle and wraps from 16'hFFFF to 0. `frame_done_o` pulses high on that same cycle.
- `enable_i` falling mid-frame: the current frame completes in full, then the block goes to IDLE. Frames are never truncated.
- `single_shot_i` outside IDLE is ignored.
- `pattern_sel_i` changes mid-frame take effect only at the next frame start.

## Timing
- Reset (`rst_i` high at a rising edge): on the next edge, state = IDLE and every output = 0, including `frame_cnt_o` and `busy_o`. Reset mid-frame aborts immediately; `fv_o`/`lv_o` drop the cycle after.
- Start latency: if `enable_i` is sampled high in IDLE at edge N, then `fv_o` and `busy_o` are high from edge N+1.
- First `lv_o` high: edge N+1+V_FRONT.
- Pixel alignment: `pd_o` is valid in the same cycle as `lv_o`. The first pixel of each line has x = 0.
- Frame length (fv high): V_FRONT + V_ACTIVE·H_ACTIVE + (V_ACTIVE−1)·H_BLANK + V_BACK cycles.
- Frame period (continuous): frame length + V_BLANK.
- `frame_done_o` is asserted in the cycle `fv_o` first reads low.
- Single-shot return: `busy_o` falls V_BLANK cycles after `fv_o` falls.

## Test plan
All scenarios use H_ACTIVE=8, H_BLANK=2, V_ACTIVE=3, V_FRONT=2, V_BACK=1, V_BLANK=4. This gives fv high = 31 cycles and a period of 35.

1. Reset, then `enable_i`=1 with pattern 0 for 3 frames → fv high 31 cycles, period 35; per frame, 3 lv bursts of 8 separated by 2 low cycles; `pd_o` = 0..7 each line; `frame_cnt_o` = 1, 2, 3; exactly 3 `frame_done_o` pulses.
2. Pattern 1 → line y=2 reads 2..9; pattern 3 → the first frame's pixels match the reference LFSR from 10'h3FF, and the second frame repeats the first exactly.
3. `single_shot_i` pulse with `enable_i`=0 → exactly one frame, `busy_o` low at cycle 36 after the pulse; a second pulse sent mid-frame → no extra frame.
4. `enable_i` dropped during line 1 → the frame completes with all 24 pixels and fv low for 4 cycles, then IDLE.
5. `rst_i` asserted in HBLANK → next cycle all outputs 0; restart gives x = 0, y = 0 and the LFSR reseeded.
6. Counter wrap: force `frame_cnt_o` to 16'hFFFF, run one frame → reads 0; with pattern 2 the following frame's pixels = 0.
